// File: rtl/aes_package.sv
// AES shared constants and types for the inverse key schedule.
`default_nettype none

package aes_package;
   localparam int         WORD_SIZE  = 32;
   localparam int         KEY_SIZE   = 128;
   localparam int         NUM_ROUNDS = 10;
   localparam logic [7:0] RCON_LAST  = 8'h36;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } inv_ks_state_e;
endpackage

`default_nettype wire

// File: rtl/inv_key_step.sv
// One backward AES-128 key-expansion step: round key N -> round key N-1.
`default_nettype none

module inv_key_step #(
   parameter int WORD_SIZE = 32
) (
   input  logic [4*WORD_SIZE-1:0] key,
   input  logic [7:0]             rcon,
   output logic [4*WORD_SIZE-1:0] prev_key
);
   logic [WORD_SIZE-1:0] a, b, c, d;
   logic [WORD_SIZE-1:0] a_n, b_n, c_n, d_n;
   logic [WORD_SIZE-1:0] rot, sub;

   assign {a, b, c, d} = key;

   assign d_n = d ^ c;
   assign c_n = c ^ b;
   assign b_n = b ^ a;

   assign rot = {d_n[WORD_SIZE-9:0], d_n[WORD_SIZE-1 -: 8]};

   for (genvar i = 0; i < WORD_SIZE/8; i++) begin : g_sbox
      sbox u_sbox (
         .in_byte  (rot[8*i +: 8]),
         .out_byte (sub[8*i +: 8])
      );
   end

   assign a_n      = a ^ sub ^ {rcon, {(WORD_SIZE-8){1'b0}}};
   assign prev_key = {a_n, b_n, c_n, d_n};
endmodule

`default_nettype wire

// File: rtl/sbox.sv
// AES forward S-box, table lookup.
`default_nettype none

module sbox (
   input  logic [7:0] in_byte,
   output logic [7:0] out_byte
);
   // Entry 0 sits in the most significant byte.
   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   assign out_byte = SBOX_TABLE[{~in_byte, 3'b000} +: 8];
endmodule

`default_nettype wire

// File: rtl/inv_key_schedule.sv
// Iterative AES-128 inverse key scheduler emitting round keys 10..0.
// Optional INV_KEY_SCHED_ZEROIZE_EN clears the key and rcon on completion.
`default_nettype none

module inv_key_schedule #(
   parameter int WORD_SIZE = aes_package::WORD_SIZE
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            start_i,
   input  logic [aes_package::KEY_SIZE-1:0] last_key_i,
   output logic                            idle_o,
   output logic                            rk_valid_o,
   input  logic                            rk_ready_i,
   output logic [aes_package::KEY_SIZE-1:0] rk_o,
   output logic [3:0]                      rk_round_o,
   output logic                            done_o
);
   import aes_package::*;

   inv_ks_state_e         state_q, state_d;
   logic [KEY_SIZE-1:0]   key_q, key_d, prev_key;
   logic [3:0]            round_q, round_d;
   logic [7:0]            rcon_q, rcon_d;
   logic                  done_q, done_d;
   logic                  handshake;

   function automatic logic [7:0] inv_xtime(input logic [7:0] r);
      return r[0] ? (((r ^ 8'h1B) >> 1) | 8'h80) : (r >> 1);
   endfunction

   inv_key_step #(.WORD_SIZE(WORD_SIZE)) u_step (
      .key      (key_q),
      .rcon     (rcon_q),
      .prev_key (prev_key)
   );

   assign handshake = (state_q == RUN) && rk_ready_i;

   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      round_d = round_q;
      rcon_d  = rcon_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = RUN;
               key_d   = last_key_i;
               round_d = 4'(NUM_ROUNDS);
               rcon_d  = RCON_LAST;
            end
         end
         RUN: begin
            if (handshake) begin
               if (round_q == 4'd0) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
`ifdef INV_KEY_SCHED_ZEROIZE_EN
                  key_d   = '0;
                  rcon_d  = '0;
`endif
               end else begin
                  key_d   = prev_key;
                  round_d = round_q - 4'd1;
                  rcon_d  = inv_xtime(rcon_q);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         key_q   <= '0;
         round_q <= '0;
         rcon_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         round_q <= round_d;
         rcon_q  <= rcon_d;
         done_q  <= done_d;
      end
   end

   assign rk_o       = key_q;
   assign rk_round_o = round_q;
   assign rk_valid_o = (state_q == RUN);
   assign idle_o     = (state_q == IDLE);
   assign done_o     = done_q;
endmodule

`default_nettype wire

// File: tb/tb_inv_key_schedule.sv
// Self-checking bench for inv_key_schedule using the FIPS-197 A.1 schedule.
`default_nettype none

module tb_inv_key_schedule;
   logic         clk = 1'b0;
   logic         rst_n;
   logic         start_i;
   logic [127:0] last_key_i;
   logic         idle_o;
   logic         rk_valid_o;
   logic         rk_ready_i;
   logic [127:0] rk_o;
   logic [3:0]   rk_round_o;
   logic         done_o;

   typedef struct {
      logic [3:0]   round;
      logic [127:0] key;
   } rk_vec_t;

   rk_vec_t      vecs[11];
   rk_vec_t      sb[$];
   int           n_checks = 0;
   int           n_fail   = 0;
   logic         prev_stall = 1'b0;
   logic [127:0] prev_key;
   logic [3:0]   prev_round;

   localparam logic [127:0] KEY10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] KEY0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;

   always #5 clk = ~clk;

   inv_key_schedule dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (start_i),
      .last_key_i (last_key_i),
      .idle_o     (idle_o),
      .rk_valid_o (rk_valid_o),
      .rk_ready_i (rk_ready_i),
      .rk_o       (rk_o),
      .rk_round_o (rk_round_o),
      .done_o     (done_o)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard: every accepted key is popped and compared in order.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("stall_key_stable", rk_o, prev_key);
            chk("stall_round_stable", 128'(rk_round_o), 128'(prev_round));
         end
         if (rk_valid_o && rk_ready_i) begin
            if (sb.size() == 0) begin
               chk("unexpected_key", 128'(1), 128'(0));
            end else begin
               rk_vec_t e;
               e = sb.pop_front();
               chk("sb_round", 128'(rk_round_o), 128'(e.round));
               chk("sb_key", rk_o, e.key);
            end
         end
         prev_stall = rk_valid_o && !rk_ready_i;
         prev_key   = rk_o;
         prev_round = rk_round_o;
      end
   end

   task automatic push_expected();
      for (int i = 0; i < 11; i++) sb.push_back(vecs[i]);
   endtask

   // Called at posedge+1; returns once done_o is seen, or flags a timeout.
   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (!done_o && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      if (!done_o) chk({name, "_timeout"}, 128'(0), 128'(1));
   endtask

   task automatic check_reset_outputs(input string name);
      chk({name, "_idle"},  128'(idle_o),     128'(1));
      chk({name, "_valid"}, 128'(rk_valid_o), 128'(0));
      chk({name, "_rk"},    rk_o,             128'(0));
      chk({name, "_round"}, 128'(rk_round_o), 128'(0));
      chk({name, "_done"},  128'(done_o),     128'(0));
   endtask

   initial begin
      int           cyc;
      int           zeros;
      logic [127:0] key_at_done;

      vecs[0]  = '{4'd10, KEY10};
      vecs[1]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e};
      vecs[2]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f};
      vecs[3]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
      vecs[4]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
      vecs[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
      vecs[6]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
      vecs[7]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
      vecs[8]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
      vecs[9]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
      vecs[10] = '{4'd0,  KEY0};

`ifdef INV_KEY_SCHED_ZEROIZE_EN
      key_at_done = '0;
`else
      key_at_done = KEY0;
`endif

      rst_n = 1'b0; start_i = 1'b0; rk_ready_i = 1'b0; last_key_i = '0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Unstalled run: exact cycle timing.
      rk_ready_i = 1'b1;
      last_key_i = KEY10;
      start_i    = 1'b1;
      push_expected();
      @(posedge clk); #1;
      start_i = 1'b0;
      chk("t1_valid", 128'(rk_valid_o), 128'(1));
      chk("t1_idle", 128'(idle_o), 128'(0));
      cyc = 1;
      while (!done_o && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("done_cycle", 128'(cyc), 128'(12));
      chk("done_idle", 128'(idle_o), 128'(1));
      chk("done_rk", rk_o, key_at_done);
      @(posedge clk); #1;
      chk("done_pulse", 128'(done_o), 128'(0));
      chk("post_rk", rk_o, key_at_done);

      // Random back-pressure, at most five consecutive stall cycles.
      start_i = 1'b1;
      push_expected();
      @(posedge clk); #1;
      start_i = 1'b0;
      zeros = 0;
      cyc = 0;
      while (!done_o && cyc < 300) begin
         if (zeros >= 5 || $urandom_range(0, 1) == 1) begin
            rk_ready_i = 1'b1; zeros = 0;
         end else begin
            rk_ready_i = 1'b0; zeros++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      chk("stall_done", 128'(done_o), 128'(1));
      rk_ready_i = 1'b1;
      chk("stall_sb_empty", 128'(sb.size()), 128'(0));

      // start_i held through RUN with a different key must be ignored.
      @(posedge clk); #1;
      start_i = 1'b1;
      push_expected();
      @(posedge clk); #1;
      last_key_i = ~KEY10;
      cyc = 0;
      while (!done_o && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
      start_i = 1'b0;
      last_key_i = KEY10;
      chk("hold_done", 128'(done_o), 128'(1));

      // Back-to-back start in the done_o cycle.
      @(posedge clk); #1;
      start_i = 1'b1;
      push_expected();
      @(posedge clk); #1;
      start_i = 1'b0;
      wait_done("b2b_first");
      start_i = 1'b1;
      push_expected();
      @(posedge clk); #1;
      start_i = 1'b0;
      chk("b2b_valid", 128'(rk_valid_o), 128'(1));
      chk("b2b_round", 128'(rk_round_o), 128'(10));
      chk("b2b_key", rk_o, KEY10);
      wait_done("b2b_second");

      // Asynchronous reset in round 5, then a fresh full sequence.
      @(posedge clk); #1;
      start_i = 1'b1;
      push_expected();
      @(posedge clk); #1;
      start_i = 1'b0;
      cyc = 0;
      while (rk_round_o != 4'd5 && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("rst_reach_r5", 128'(rk_round_o), 128'(5));
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      sb.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b1;
      push_expected();
      @(posedge clk); #1;
      start_i = 1'b0;
      wait_done("after_rst");
      chk("after_rst_rk", rk_o, key_at_done);
      chk("final_sb_empty", 128'(sb.size()), 128'(0));

      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

`default_nettype wire
